sample_serializer: RTL and testbench
====================================

# sample_serializer

Parallel-to-serial transmitter for signed filter samples. It accepts one N-bit two's-complement sample per valid/ready handshake and shifts it out MSB-first on a single serial line with a frame-sync pulse. It sits at the output of the IIR datapath, after the final pipeline register, and drives the serial sample link toward the downstream converter/receiver.

## Interface
- N, 16, sample width in bits (N ≥ 2)
- DIV, 4, clock cycles per serial bit (DIV ≥ 1)
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  reset, synchronous, active-low; clock CLK
- din  input  N  signed sample to transmit
- din_valid  input  1  din holds a sample to send
- din_ready  output  1  block can accept a sample this cycle
- sdo  output  1  serial data out, MSB first
- fs  output  1  frame sync, high during the whole first (MSB) bit period
- busy  output  1  frame in progress

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with PARITY_EN).
- IDLE:
  - din_ready = 1, sdo = 0, fs = 0, busy = 0.
  - If din_valid && din_ready is sampled at an edge, din is latched into the shift register, the bit counter is cleared, the divider is cleared, and the state becomes SHIFT.
- SHIFT:
  - sdo = shift-register MSB; each bit is held exactly DIV cycles.
  - When the divider reaches DIV-1, the register shifts left by 1 and the bit counter increments.
  - After bit N-1 completes, the state goes to PAR if PARITY_EN is defined, otherwise to IDLE.
- fs = 1 only while the bit counter is 0 in SHIFT.
- busy = 1 in SHIFT and PAR.
- din_ready = RST && (state == IDLE), derived combinationally. It is never high in SHIFT or PAR.
- din is ignored whenever din_ready = 0. din_valid may stay high across frames, and no sample is accepted twice.
- Values are sent as raw two's-complement bits. There is no sign extension or saturation.
- Divider width is clog2(DIV), minimum 1. Bit counter width is clog2(N+1).

## Timing
- Reset (RST low at an edge):
  - state = IDLE; shift register, divider and counter = 0.
  - sdo = 0, fs = 0, busy = 0.
  - din_ready reads 0 while RST is low.
- Reset mid-frame aborts the frame immediately. The partial frame is not resumed and the sample is lost.
- Handshake at edge k: sdo = din[N-1] and fs = 1 from edge k through edge k+DIV.
- Frame length is N·DIV cycles, or (N+1)·DIV with PARITY_EN. Frame bits appear on sdo starting the cycle after the handshake.
- Outputs in the first cycle after the last bit period: sdo = 0, busy = 0, din_ready = 1.
- Minimum spacing between frame starts is N·DIV+1 cycles, because of the one mandatory IDLE cycle.
- sdo, fs and busy are registered outputs with no combinational path from inputs.

## Configuration
- Macro `SAMPLE_SERIALIZER_PARITY_EN`.
- Defined:
  - The PAR state follows the last data bit for DIV cycles.
  - sdo = even parity, i.e. the XOR of all N bits latched at the handshake. The parity is computed at latch time and held in a register.
  - busy stays high during PAR.
- Undefined: there is no PAR state, no parity register, and the frame is exactly N bits.

## Structure
- Shared package `serializer_pkg`:
  - state enum (IDLE, SHIFT, PAR)
  - default width constant SAMPLE_W = 16
  - default DIV_DEFAULT = 4
- One sub-module, `bit_timer`:
  - a DIV-cycle divider plus a bit counter
  - inputs: start pulse, terminal count N
  - outputs: bit_tick, last_bit
- The top level holds the FSM, the shift register and the parity register.

## Test plan
- N=16, DIV=4, din=16'hA5C3 with a one-cycle din_valid:
  - sdo = 1010 0101 1100 0011, each bit 4 cycles.
  - fs is high for the first 4 cycles.
  - din_ready is low for 64 cycles, then high.
- din=16'sh8000 (negative full scale), DIV=1: sdo = 1 then fifteen 0s. busy is high for exactly 16 cycles.
- din_valid held high with din changing every cycle:
  - Only the sample present at each handshake is sent.
  - Frame starts are exactly 65 cycles apart (DIV=4).
- RST low at cycle 20 of a frame:
  - sdo, fs and busy are 0 at the next edge, with din_ready = 0 while reset is held.
  - After release: IDLE, din_ready = 1, and the next handshake starts a fresh frame at its MSB.
- With PARITY_EN:
  - din=16'h0001 gives parity bit 1 after the data, and the frame is 68 cycles.
  - din=16'hA5C3 gives parity bit 0.
- din_valid pulsed high during SHIFT: no effect. The frame completes unchanged and no extra frame follows.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared definitions for the sample serializer: default sizes, FSM state
// encoding and a small width helper used by the divider.
package serializer_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  // Plain vector constants so state registers stay legacy-compatible
  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_PAR   = 2'(PAR);

  // Counter width able to hold 0..v-1, never narrower than one bit
  function automatic int width_of(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sample_serializer_bit_timer.sv
// Bit timer for the sample serializer: a DIV-cycle divider that produces one
// bit_tick per serial bit period, plus a bit counter that flags the last
// data bit against the terminal count.
import serializer_pkg::*;

module bit_timer #(
  parameter int N   = SAMPLE_W,
  parameter int DIV = DIV_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic                     en,
  input  logic [$clog2(N+1)-1:0]   term,
  output logic                     bit_tick,
  output logic                     last_bit
);

  localparam int DW = width_of(DIV);
  localparam int CW = $clog2(N+1);

  logic [DW-1:0] div;
  logic [CW-1:0] cnt;

  assign bit_tick = en && (div == DW'(DIV - 1));
  assign last_bit = (cnt == (term - 1'b1));

  // Divider wraps every DIV cycles while running; each wrap advances the bit count
  always_ff @(posedge CLK) begin
    if (!RST) begin
      div <= '0;
      cnt <= '0;
    end else if (start) begin
      div <= '0;
      cnt <= '0;
    end else if (en) begin
      if (div == DW'(DIV - 1)) begin
        div <= '0;
        cnt <= cnt + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_serializer.sv
// Parallel-to-serial transmitter for signed samples: one sample per
// valid/ready handshake, shifted out MSB-first, each bit held DIV cycles,
// with a frame-sync pulse over the MSB period. sdo, fs and busy are flops
// loaded from the next-state values so the bits line up with the state.
// Optional even-parity trailer bit: define SAMPLE_SERIALIZER_PARITY_EN.
import serializer_pkg::*;

module sample_serializer #(
  parameter int N   = SAMPLE_W,
  parameter int DIV = DIV_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic signed [N-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                sdo,
  output logic                fs,
  output logic                busy
);

  localparam int CW = $clog2(N+1);

  logic [1:0]          state, state_n;
  logic signed [N-1:0] sreg, sreg_n;
  logic                start, en, bit_tick, last_bit;
  logic                sdo_n, fs_n, busy_n;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
  logic                par, par_n;
`endif

  assign din_ready = RST && (state == ST_IDLE);
  assign en        = (state != ST_IDLE);

  bit_timer #(.N(N), .DIV(DIV)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .en       (en),
    .term     (CW'(N)),
    .bit_tick (bit_tick),
    .last_bit (last_bit)
  );

  // Next-state: latch on handshake, shift on each bit period, leave after the last bit
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    start   = 1'b0;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
    par_n   = par;
`endif
    case (state)
      ST_IDLE: begin
        if (din_valid && din_ready) begin
          start   = 1'b1;
          sreg_n  = din;
          state_n = ST_SHIFT;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
          par_n   = ^din;
`endif
        end
      end
      ST_SHIFT: begin
        if (bit_tick) begin
          sreg_n = sreg << 1;
          if (last_bit) begin
`ifdef SAMPLE_SERIALIZER_PARITY_EN
            state_n = ST_PAR;
`else
            state_n = ST_IDLE;
`endif
          end
        end
      end
`ifdef SAMPLE_SERIALIZER_PARITY_EN
      ST_PAR: begin
        if (bit_tick) state_n = ST_IDLE;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle; fs holds from the handshake until the first bit wrap
  always_comb begin
    sdo_n = 1'b0;
    if (state_n == ST_SHIFT) sdo_n = sreg_n[N-1];
`ifdef SAMPLE_SERIALIZER_PARITY_EN
    else if (state_n == ST_PAR) sdo_n = par_n;
`endif
    fs_n   = (state_n == ST_SHIFT) && (start || (fs && !bit_tick));
    busy_n = (state_n != ST_IDLE);
  end

  // State, data and registered outputs; reset aborts any frame in progress
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
      sreg  <= '0;
      sdo   <= 1'b0;
      fs    <= 1'b0;
      busy  <= 1'b0;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      sdo   <= sdo_n;
      fs    <= fs_n;
      busy  <= busy_n;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
      par   <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: a DIV=4 and a DIV=1 instance (N=16) driven
// with directed and random samples, checked cycle by cycle against a
// frame model computed from bit positions and the frame length.
`timescale 1ns/1ps

module tb_sample_serializer;

`ifdef SAMPLE_SERIALIZER_PARITY_EN
  localparam int FL = 17;
  localparam bit PEN = 1'b1;
`else
  localparam int FL = 16;
  localparam bit PEN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic signed [15:0] d4 = '0, d1 = '0;
  logic v4 = 1'b0, v1 = 1'b0;
  logic rdy4, sdo4, fs4, busy4;
  logic rdy1, sdo1, fs1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  sample_serializer #(.N(16), .DIV(4)) u4 (
    .CLK(CLK), .RST(RST), .din(d4), .din_valid(v4),
    .din_ready(rdy4), .sdo(sdo4), .fs(fs4), .busy(busy4)
  );

  sample_serializer #(.N(16), .DIV(1)) u1 (
    .CLK(CLK), .RST(RST), .din(d1), .din_valid(v1),
    .din_ready(rdy1), .sdo(sdo1), .fs(fs1), .busy(busy1)
  );

  // Expected {sdo, fs, busy, din_ready} t cycles after the handshake edge
  function automatic logic [3:0] model_out(input logic [15:0] s, input int div, input int t);
    int b;
    logic sd;
    if (t < 0 || t >= FL * div) return 4'b0001;
    b = t / div;
    if (b < 16) sd = s[15 - b];
    else        sd = PEN ? ^s : 1'b0;
    return {sd, (b == 0), 1'b1, 1'b0};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_frame4(input logic [15:0] s, input string tag);
    int w;
    logic [3:0] got, exp;
    w = 0;
    while (rdy4 !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    n_cmp++;
    if (w >= 200) begin
      n_err++;
      $display("FAIL %s ready_wait: din_ready=%b after %0d cycles, want 1", tag, rdy4, w);
    end
    d4 = s;
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    d4 = 16'($urandom);
    for (int t = 0; t <= FL * 4; t++) begin
      @(negedge CLK);
      got = {sdo4, fs4, busy4, rdy4};
      exp = model_out(s, 4, t);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s t=%0d sdo/fs/busy/rdy got %b want %b", tag, t, got, exp);
      end
      tick();
    end
  endtask

  // Streams valid per mode (0: held high, 1: one pulse then pulses mid-frame)
  task automatic drive_stream4(input int mode, input int ncyc, output int frames, output int exp_frames);
    int t, last;
    logic [15:0] cur;
    logic pfs, hs;
    logic [3:0] got, exp;
    t = -1; last = -1; cur = '0; pfs = 1'b0;
    frames = 0; exp_frames = 0;
    for (int c = 0; c < ncyc + FL * 4 + 4; c++) begin
      if (c < ncyc) v4 = (mode == 0) ? 1'b1 : ((c == 0) || (c >= 8 && c < 40));
      else          v4 = 1'b0;
      d4 = 16'($urandom);
      hs = v4 && (t < 0 || t >= FL * 4);
      @(negedge CLK);
      got = {sdo4, fs4, busy4, rdy4};
      exp = model_out(cur, 4, t);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL stream%0d c=%0d sdo/fs/busy/rdy got %b want %b", mode, c, got, exp);
      end
      if (fs4 === 1'b1 && pfs !== 1'b1) begin
        frames++;
        if (last >= 0) begin
          n_cmp++;
          if (c - last != FL * 4 + 1) begin
            n_err++;
            $display("FAIL stream%0d spacing got %0d want %0d", mode, c - last, FL * 4 + 1);
          end
        end
        last = c;
      end
      pfs = fs4;
      if (hs) begin
        cur = d4;
        exp_frames++;
      end
      tick();
      t = hs ? 0 : ((t < 0) ? -1 : t + 1);
    end
    v4 = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      got = {sdo4, fs4, busy4, rdy4};
      n_cmp++;
      if (got !== 4'b0000) begin
        n_err++;
        $display("FAIL reset4 sdo/fs/busy/rdy got %b want 0000", got);
      end
      got = {sdo1, fs1, busy1, rdy1};
      n_cmp++;
      if (got !== 4'b0000) begin
        n_err++;
        $display("FAIL reset1 sdo/fs/busy/rdy got %b want 0000", got);
      end
      tick();
    end
    RST = 1'b1;
    @(negedge CLK);
    got = {sdo4, fs4, busy4, rdy4};
    n_cmp++;
    if (got !== 4'b0001) begin
      n_err++;
      $display("FAIL release4 sdo/fs/busy/rdy got %b want 0001", got);
    end
    got = {sdo1, fs1, busy1, rdy1};
    n_cmp++;
    if (got !== 4'b0001) begin
      n_err++;
      $display("FAIL release1 sdo/fs/busy/rdy got %b want 0001", got);
    end
    tick();
  endtask

  task automatic test_a5c3();
    run_frame4(16'hA5C3, "a5c3");
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 6; i++) run_frame4(16'($urandom), "rand4");
  endtask

  task automatic test_div1();
    logic [15:0] s;
    logic [3:0] got, exp;
    int bz, w;
    for (int i = 0; i < 5; i++) begin
      s = (i == 0) ? 16'h8000 : 16'($urandom);
      w = 0;
      while (rdy1 !== 1'b1 && w < 50) begin
        tick();
        w++;
      end
      d1 = s;
      v1 = 1'b1;
      tick();
      v1 = 1'b0;
      bz = 0;
      for (int t = 0; t <= FL; t++) begin
        @(negedge CLK);
        got = {sdo1, fs1, busy1, rdy1};
        exp = model_out(s, 1, t);
        if (busy1 === 1'b1) bz++;
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL div1 s=%h t=%0d sdo/fs/busy/rdy got %b want %b", s, t, got, exp);
        end
        tick();
      end
      n_cmp++;
      if (bz != FL) begin
        n_err++;
        $display("FAIL div1_busy s=%h busy cycles got %0d want %0d", s, bz, FL);
      end
    end
  endtask

  task automatic test_back_to_back();
    int fr, efr;
    drive_stream4(0, 4 * (FL * 4 + 1), fr, efr);
    n_cmp++;
    if (fr != efr) begin
      n_err++;
      $display("FAIL back_to_back frames got %0d want %0d", fr, efr);
    end
  endtask

  task automatic test_valid_during_shift();
    int fr, efr;
    drive_stream4(1, 60, fr, efr);
    n_cmp++;
    if (fr != 1 || efr != 1) begin
      n_err++;
      $display("FAIL valid_in_shift frames got %0d want 1", fr);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] s;
    logic [3:0] got, exp;
    s = 16'($urandom) | 16'h8000;
    d4 = s;
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      got = {sdo4, fs4, busy4, rdy4};
      exp = model_out(s, 4, t);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL pre_reset t=%0d sdo/fs/busy/rdy got %b want %b", t, got, exp);
      end
      tick();
    end
    RST = 1'b0;
    v4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge CLK);
      got = {sdo4, fs4, busy4, rdy4};
      n_cmp++;
      if (got !== 4'b0000) begin
        n_err++;
        $display("FAIL mid_reset cyc=%0d sdo/fs/busy/rdy got %b want 0000", i, got);
      end
    end
    v4 = 1'b0;
    tick();
    RST = 1'b1;
    @(negedge CLK);
    got = {sdo4, fs4, busy4, rdy4};
    n_cmp++;
    if (got !== 4'b0001) begin
      n_err++;
      $display("FAIL after_reset sdo/fs/busy/rdy got %b want 0001", got);
    end
    tick();
    run_frame4(16'($urandom), "post_reset");
  endtask

`ifdef SAMPLE_SERIALIZER_PARITY_EN
  task automatic test_parity();
    run_frame4(16'h0001, "par0001");
    run_frame4(16'hA5C3, "para5c3");
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_a5c3();
    test_div1();
    test_random_frames();
    test_back_to_back();
    test_valid_during_shift();
    test_reset_midframe();
`ifdef SAMPLE_SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
